mandelbrot_engine_scheduler: RTL

Sequences a pool of `NUM_ENGINES` escape-time depth engines (pixel_to_complex + depth calculator pairs) so that several pixels are computed in parallel. It hands raster-order pixel coordinates to free engines round-robin, captures each engine's colour on completion, and retires results strictly in raster order onto a valid/ready pixel interface. That interface feeds the RGB stream packer, with start-of-frame and end-of-line flags attached.

---
 rtl/mandelbrot_engine_scheduler_if.sv | 32 +++
 rtl/mandelbrot_engine_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mandelbrot_engine_scheduler_if.sv
// Handshake bundle between the engine scheduler, its depth-engine pool and the pixel sink.
// master = scheduler side, slave = engines + downstream packer.
interface mandelbrot_engine_scheduler_if #(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned COLOR_W     = 24
);
    localparam int unsigned CRD_W = 11;

    logic                           enable;
    logic [NUM_ENGINES-1:0]         eng_start;
    logic [CRD_W-1:0]               eng_x;
    logic [CRD_W-1:0]               eng_y;
    logic [NUM_ENGINES-1:0]         eng_done;
    logic [NUM_ENGINES*COLOR_W-1:0] eng_color;
    logic [COLOR_W-1:0]             pix_color;
    logic                           pix_valid;
    logic                           pix_ready;
    logic                           pix_sof;
    logic                           pix_eol;
    logic                           frame_done;
    logic                           err;

    modport master (
        input  enable, eng_done, eng_color, pix_ready,
        output eng_start, eng_x, eng_y, pix_color, pix_valid, pix_sof, pix_eol, frame_done, err
    );

    modport slave (
        output enable, eng_done, eng_color, pix_ready,
        input  eng_start, eng_x, eng_y, pix_color, pix_valid, pix_sof, pix_eol, frame_done, err
    );
endinterface

// File: rtl/mandelbrot_engine_scheduler.sv
// Round-robin dispatcher for a pool of escape-time engines; retires colours in raster order
// onto a valid/ready pixel stream with start-of-frame / end-of-line flags.
module mandelbrot_engine_scheduler #(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned X_SIZE      = 640,
    parameter int unsigned Y_SIZE      = 480,
    parameter int unsigned COLOR_W     = 24
) (
    input  logic                                 out_stream_aclk,
    input  logic                                 reset,
    mandelbrot_engine_scheduler_if.master        bus
);
    localparam int unsigned PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int unsigned CRD_W = 11;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ENGINES - 1);
    localparam logic [CRD_W-1:0] X_LAST   = CRD_W'(X_SIZE - 1);
    localparam logic [CRD_W-1:0] Y_LAST   = CRD_W'(Y_SIZE - 1);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_BUSY, SLOT_DONE} slot_e;

    slot_e              slot_q [NUM_ENGINES];
    slot_e              slot_d [NUM_ENGINES];
    logic [COLOR_W-1:0] hold_q [NUM_ENGINES];
    logic [COLOR_W-1:0] hold_d [NUM_ENGINES];

    logic [PTR_W-1:0]       d_q, d_d, r_q, r_d;
    logic [CRD_W-1:0]       xd_q, xd_d, yd_q, yd_d;
    logic [CRD_W-1:0]       xr_q, xr_d, yr_q, yr_d;
    logic [CRD_W-1:0]       eng_x_q, eng_x_d, eng_y_q, eng_y_d;
    logic [NUM_ENGINES-1:0] start_q, start_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_q, err_d;

    logic               dispatch_c;
    logic               retire_c;
    logic               pix_valid_c;
    logic [COLOR_W-1:0] pix_color_c;

    // Decode the slots addressed by the dispatch and retire pointers.
    always_comb begin
        pix_valid_c = 1'b0;
        pix_color_c = '0;
        dispatch_c  = 1'b0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (r_q == PTR_W'(i)) begin
                pix_valid_c = (slot_q[i] == SLOT_DONE);
                pix_color_c = hold_q[i];
            end
            if (d_q == PTR_W'(i)) begin
                dispatch_c = bus.enable && (slot_q[i] == SLOT_FREE);
            end
        end
        retire_c = pix_valid_c && bus.pix_ready;
    end

    // Next state. Dispatch, capture and retire need FREE, BUSY and DONE respectively,
    // so at most one of them touches any slot in a given cycle.
    always_comb begin
        slot_d       = slot_q;
        hold_d       = hold_q;
        d_d          = d_q;
        r_d          = r_q;
        xd_d         = xd_q;
        yd_d         = yd_q;
        xr_d         = xr_q;
        yr_d         = yr_q;
        eng_x_d      = eng_x_q;
        eng_y_d      = eng_y_q;
        start_d      = '0;
        frame_done_d = 1'b0;
        err_d        = err_q;

        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (bus.eng_done[i]) begin
                if (slot_q[i] == SLOT_BUSY) begin
                    slot_d[i] = SLOT_DONE;
                    hold_d[i] = bus.eng_color[i*COLOR_W +: COLOR_W];
                end else begin
                    err_d = 1'b1;
                end
            end
            if (dispatch_c && (d_q == PTR_W'(i))) begin
                slot_d[i]  = SLOT_BUSY;
                start_d[i] = 1'b1;
            end
            if (retire_c && (r_q == PTR_W'(i))) begin
                slot_d[i] = SLOT_FREE;
            end
        end

        if (dispatch_c) begin
            eng_x_d = xd_q;
            eng_y_d = yd_q;
            d_d     = (d_q == PTR_LAST) ? '0 : d_q + PTR_W'(1);
            if (xd_q == X_LAST) begin
                xd_d = '0;
                yd_d = (yd_q == Y_LAST) ? '0 : yd_q + CRD_W'(1);
            end else begin
                xd_d = xd_q + CRD_W'(1);
            end
        end

        if (retire_c) begin
            r_d          = (r_q == PTR_LAST) ? '0 : r_q + PTR_W'(1);
            frame_done_d = (xr_q == X_LAST) && (yr_q == Y_LAST);
            if (xr_q == X_LAST) begin
                xr_d = '0;
                yr_d = (yr_q == Y_LAST) ? '0 : yr_q + CRD_W'(1);
            end else begin
                xr_d = xr_q + CRD_W'(1);
            end
        end
    end

    always_ff @(posedge out_stream_aclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                slot_q[i] <= SLOT_FREE;
                hold_q[i] <= '0;
            end
            d_q          <= '0;
            r_q          <= '0;
            xd_q         <= '0;
            yd_q         <= '0;
            xr_q         <= '0;
            yr_q         <= '0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            start_q      <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            hold_q       <= hold_d;
            d_q          <= d_d;
            r_q          <= r_d;
            xd_q         <= xd_d;
            yd_q         <= yd_d;
            xr_q         <= xr_d;
            yr_q         <= yr_d;
            eng_x_q      <= eng_x_d;
            eng_y_q      <= eng_y_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.eng_start  = start_q;
    assign bus.eng_x      = eng_x_q;
    assign bus.eng_y      = eng_y_q;
    assign bus.pix_valid  = pix_valid_c;
    assign bus.pix_color  = pix_color_c;
    assign bus.pix_sof    = (xr_q == '0) && (yr_q == '0);
    assign bus.pix_eol    = (xr_q == X_LAST);
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;

endmodule
